bus_arbiter: RTL and testbench

- Shares the single AHB-lite master front-end (bus controller start/addr/write/wdata in; ready/rdata/resp out) between N_REQ requesters, e.g. instruction fetch (req 0) and load/store unit (req 1) of the RV32E core.
- Selects one requester, sequences one single-word transfer through address and data phases, then returns read data and response to the owner with a one-cycle done pulse.
- One transfer outstanding at a time; no bursts.

---
 rtl/bus_arbiter.sv | 118 +++++++++++
 tb/tb_bus_arbiter.sv | 241 ++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_arbiter.sv
// Arbitrates N_REQ requesters onto one single-word AHB-lite bus front-end.
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default is fixed priority (index 0 highest).
module bus_arbiter #(
  parameter int unsigned N_REQ = 2,
  parameter int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_write,
  input  logic [N_REQ*32-1:0]   req_addr,
  input  logic [N_REQ*32-1:0]   req_wdata,
  output logic [N_REQ-1:0]      done,
  output logic [N_REQ-1:0]      err,
  output logic [31:0]           rdata,
  output logic                  bus_start,
  output logic                  bus_write,
  output logic [31:0]           bus_addr,
  output logic [31:0]           bus_wdata,
  input  logic                  bus_ready,
  input  logic [31:0]           bus_rdata,
  input  logic                  bus_resp,
  output logic [IDX_W-1:0]      owner,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;

  state_t           state;
  state_t           state_next;
  logic [IDX_W-1:0] win;
  logic             found;
  logic [IDX_W-1:0] idx;
  logic [IDX_W:0]   sum;
  logic [31:0]      addr_arr  [N_REQ];
  logic [31:0]      wdata_arr [N_REQ];

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] ptr;
`endif

  for (genvar g = 0; g < int'(N_REQ); g++) begin : g_slice
    assign addr_arr[g]  = req_addr[32*g +: 32];
    assign wdata_arr[g] = req_wdata[32*g +: 32];
  end

  // Winner search plus next-state logic.
  always_comb begin
    state_next = state;
    win        = '0;
    found      = 1'b0;
    idx        = '0;
    sum        = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
`ifdef ARB_ROUND_ROBIN_EN
      sum = {1'b0, ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(N_REQ)) sum = sum - (IDX_W+1)'(N_REQ);
`else
      sum = (IDX_W+1)'(k);
`endif
      idx = IDX_W'(sum);
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    case (state)
      IDLE:    if (found) state_next = ADDR;
      ADDR:    if (bus_ready) state_next = DATA;
      DATA:    if (bus_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_next;
  end

  // Registered datapath and outputs; request fields are captured only at grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done      <= '0;
      err       <= '0;
      rdata     <= '0;
      bus_start <= 1'b0;
      bus_write <= 1'b0;
      bus_addr  <= '0;
      bus_wdata <= '0;
      owner     <= '0;
      busy      <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
      ptr       <= '0;
`endif
    end else begin
      done      <= '0;
      err       <= '0;
      bus_start <= (state_next == ADDR);
      busy      <= (state_next != IDLE);
      if (state == IDLE && found) begin
        owner     <= win;
        bus_write <= req_write[win];
        bus_addr  <= addr_arr[win];
        bus_wdata <= wdata_arr[win];
`ifdef ARB_ROUND_ROBIN_EN
        if (win == IDX_W'(N_REQ - 1)) ptr <= '0;
        else                          ptr <= win + IDX_W'(1);
`endif
      end
      if (state == DATA && bus_ready) begin
        done <= N_REQ'(1) << owner;
        if (bus_resp) err <= N_REQ'(1) << owner;
        if (!bus_write) rdata <= bus_rdata;
      end
    end
  end

endmodule

// File: tb/tb_bus_arbiter.sv
// Directed self-checking bench for bus_arbiter with two requesters.
`timescale 1ns/1ps
module tb_bus_arbiter;

  localparam int unsigned N_REQ = 2;
  localparam int unsigned IDX_W = 1;

  logic               clk = 1'b0;
  logic               rst;
  logic [N_REQ-1:0]   req;
  logic [N_REQ-1:0]   req_write;
  logic [N_REQ*32-1:0] req_addr;
  logic [N_REQ*32-1:0] req_wdata;
  logic [N_REQ-1:0]   done;
  logic [N_REQ-1:0]   err;
  logic [31:0]        rdata;
  logic               bus_start;
  logic               bus_write;
  logic [31:0]        bus_addr;
  logic [31:0]        bus_wdata;
  logic               bus_ready;
  logic [31:0]        bus_rdata;
  logic               bus_resp;
  logic [IDX_W-1:0]   owner;
  logic               busy;

  int tests = 0;
  int fails = 0;

  bus_arbiter #(.N_REQ(N_REQ)) dut (
    .clk(clk), .rst(rst), .req(req), .req_write(req_write), .req_addr(req_addr),
    .req_wdata(req_wdata), .done(done), .err(err), .rdata(rdata),
    .bus_start(bus_start), .bus_write(bus_write), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .bus_resp(bus_resp), .owner(owner), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b0; req = '0; req_write = '0; req_addr = '0; req_wdata = '0;
    bus_ready = 1'b1; bus_rdata = '0; bus_resp = 1'b0;
    #12;
    tests++;
    if ({done, err, bus_start, bus_write, busy, owner} !== '0 || bus_addr !== 32'h0 ||
        bus_wdata !== 32'h0 || rdata !== 32'h0) begin
      fails++;
      $display("FAIL reset: done=%b err=%b start=%b busy=%b owner=%0d addr=%h rdata=%h, required all zero",
               done, err, bus_start, busy, owner, bus_addr, rdata);
    end
    @(posedge clk); #1 rst = 1'b1;
  endtask

  task automatic test_read_zero_wait;
    req_addr[31:0] = 32'h0000_0100; req_write = 2'b00; bus_rdata = 32'hDEAD_BEEF;
    bus_ready = 1'b1; req = 2'b01;
    tick;
    tests++;
    if (bus_start !== 1'b1 || bus_addr !== 32'h100 || busy !== 1'b1 || done !== 2'b00) begin
      fails++;
      $display("FAIL read_addr_phase: start=%b addr=%h busy=%b done=%b, required 1 00000100 1 00",
               bus_start, bus_addr, busy, done);
    end
    tick;
    tests++;
    if (bus_start !== 1'b0 || busy !== 1'b1 || done !== 2'b00) begin
      fails++;
      $display("FAIL read_data_phase: start=%b busy=%b done=%b, required 0 1 00", bus_start, busy, done);
    end
    tick;
    req = 2'b00;
    tests++;
    if (done !== 2'b01 || err !== 2'b00 || rdata !== 32'hDEAD_BEEF || busy !== 1'b0) begin
      fails++;
      $display("FAIL read_done: done=%b err=%b rdata=%h busy=%b, required 01 00 deadbeef 0",
               done, err, rdata, busy);
    end
    tick;
    tests++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL read_done_pulse: done=%b busy=%b, required 00 0", done, busy);
    end
  endtask

  task automatic test_write_wait;
    req_addr[63:32] = 32'h2000_0004; req_wdata[63:32] = 32'h1234_5678; req_write = 2'b10;
    bus_rdata = 32'hAAAA_5555; bus_ready = 1'b1; req = 2'b10;
    tick;
    tests++;
    if (owner !== 1'b1 || bus_start !== 1'b1 || bus_write !== 1'b1 || bus_addr !== 32'h2000_0004) begin
      fails++;
      $display("FAIL write_addr_phase: owner=%0d start=%b write=%b addr=%h, required 1 1 1 20000004",
               owner, bus_start, bus_write, bus_addr);
    end
    tick;
    bus_ready = 1'b0;
    for (int w = 0; w < 2; w++) begin
      tick;
      tests++;
      if (bus_wdata !== 32'h1234_5678 || bus_start !== 1'b0 || done !== 2'b00 || busy !== 1'b1) begin
        fails++;
        $display("FAIL write_wait%0d: wdata=%h start=%b done=%b busy=%b, required 12345678 0 00 1",
                 w, bus_wdata, bus_start, done, busy);
      end
    end
    bus_ready = 1'b1;
    tick;
    req = 2'b00;
    tests++;
    if (done !== 2'b10 || err !== 2'b00 || rdata !== 32'hDEAD_BEEF) begin
      fails++;
      $display("FAIL write_done: done=%b err=%b rdata=%h, required 10 00 deadbeef", done, err, rdata);
    end
    tick;
  endtask

  task automatic test_contention;
    logic [IDX_W-1:0] exp_own [3];
`ifdef ARB_ROUND_ROBIN_EN
    exp_own[0] = 1'b0; exp_own[1] = 1'b1; exp_own[2] = 1'b0;
`else
    exp_own[0] = 1'b0; exp_own[1] = 1'b0; exp_own[2] = 1'b0;
`endif
    req_write = 2'b00; bus_ready = 1'b1; req = 2'b11;
    for (int t = 0; t < 3; t++) begin
      tick;
      tests++;
      if (owner !== exp_own[t] || bus_start !== 1'b1) begin
        fails++;
        $display("FAIL contention_grant%0d: owner=%0d start=%b, required %0d 1", t, owner, bus_start, exp_own[t]);
      end
      tick;
      tick;
      tests++;
      if (done !== (2'b01 << exp_own[t])) begin
        fails++;
        $display("FAIL contention_done%0d: done=%b, required %b", t, done, 2'b01 << exp_own[t]);
      end
    end
    req = 2'b00;
    tick;
  endtask

  task automatic test_error;
    req_addr[31:0] = 32'hFFFF_0000; req_write = 2'b00; bus_ready = 1'b1; req = 2'b01;
    tick;
    bus_resp = 1'b1;
    tick;
    tick;
    req = 2'b00;
    tests++;
    if (done !== 2'b01 || err !== 2'b01 || busy !== 1'b0) begin
      fails++;
      $display("FAIL error_done: done=%b err=%b busy=%b, required 01 01 0", done, err, busy);
    end
    bus_resp = 1'b0;
    tick;
    tests++;
    if (err !== 2'b00 || done !== 2'b00) begin
      fails++;
      $display("FAIL error_clear: err=%b done=%b, required 00 00", err, done);
    end
  endtask

  task automatic test_reset_mid;
    req_addr[31:0] = 32'h0000_0100; req_write = 2'b00; bus_ready = 1'b1; req = 2'b01;
    tick;
    tick;
    rst = 1'b0;
    #1;
    tests++;
    if (bus_start !== 1'b0 || busy !== 1'b0 || done !== 2'b00) begin
      fails++;
      $display("FAIL reset_mid: start=%b busy=%b done=%b, required 0 0 00", bus_start, busy, done);
    end
    tick;
    tests++;
    if (done !== 2'b00 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_mid_hold: done=%b busy=%b, required 00 0", done, busy);
    end
    rst = 1'b1;
    tick;
    tick;
    tests++;
    if (done !== 2'b00 || busy !== 1'b1) begin
      fails++;
      $display("FAIL reset_resume_early: done=%b busy=%b, required 00 1", done, busy);
    end
    tick;
    req = 2'b00;
    tests++;
    if (done !== 2'b01) begin
      fails++;
      $display("FAIL reset_resume_done: done=%b, required 01", done);
    end
    tick;
  endtask

  task automatic test_stability;
    req_addr[31:0] = 32'h0000_0100; req_write = 2'b00; bus_ready = 1'b1; req = 2'b01;
    tick;
    tick;
    bus_ready = 1'b0;
    req_addr[31:0] = 32'h0000_0200;
    tick;
    tests++;
    if (bus_addr !== 32'h100) begin
      fails++;
      $display("FAIL stability_data: bus_addr=%h, required 00000100", bus_addr);
    end
    bus_ready = 1'b1;
    tick;
    req = 2'b00;
    tests++;
    if (bus_addr !== 32'h100 || done !== 2'b01) begin
      fails++;
      $display("FAIL stability_done: bus_addr=%h done=%b, required 00000100 01", bus_addr, done);
    end
    tick;
  endtask

  initial begin
    test_reset;
    test_read_zero_wait;
    test_write_wait;
    test_contention;
    test_error;
    test_reset_mid;
    test_stability;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
